// File: rtl/decodificador_gray_if.sv
// Sample/result bundle between a Gray-count producer and decodificador_gray.
interface decodificador_gray_if #(
  parameter int WIDTH     = 5,
  parameter int ERR_WIDTH = 8
);
  logic                 valid_in;
  logic [WIDTH-1:0]     gray_in;
  logic [WIDTH-1:0]     binario_out;
  logic                 binario_valid;
  logic                 locked;
  logic                 error;
  logic [ERR_WIDTH-1:0] err_count;

  modport master (output valid_in, gray_in,
                  input  binario_out, binario_valid, locked, error, err_count);
  modport slave  (input  valid_in, gray_in,
                  output binario_out, binario_valid, locked, error, err_count);
endinterface

// File: rtl/decodificador_gray.sv
// Gray-to-binary receiver with sequence lock FSM and error flagging.
// Optional saturating error counter enabled by `define GRAY_ERR_CNT_EN.
module decodificador_gray #(
  parameter int WIDTH      = 5,
  parameter int SIZE       = 32,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_WIDTH  = 8
) (
  input  logic clk,
  input  logic reset,
  decodificador_gray_if.slave bus
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH:0]   SIZE_W = (WIDTH+1)'(SIZE);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(SIZE - 1);
  localparam logic [GW-1:0]    LOCK_N = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_prev, w_prev_nxt;
  logic [GW-1:0]    r_good, w_good_nxt;
  logic [WIDTH-1:0] r_bin;
  logic             r_bvalid, r_err, w_err;
  logic [WIDTH-1:0] w_bin, w_exp;
  logic             w_in_range, w_match;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) w_bin[i] = ^(bus.gray_in >> i);
  end

  assign w_in_range = {1'b0, w_bin} < SIZE_W;
  assign w_exp      = (r_prev == LAST) ? '0 : r_prev + 1'b1;
  assign w_match    = w_in_range && (w_bin == w_exp);

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_good_nxt  = r_good;
    w_err       = 1'b0;
    if (bus.valid_in) begin
      case (r_state)
        SEARCH: if (w_in_range) begin
          w_prev_nxt  = w_bin;
          w_good_nxt  = GW'(1);
          w_state_nxt = SYNC;
        end
        SYNC: if (w_match) begin
          w_prev_nxt = w_bin;
          w_good_nxt = r_good + 1'b1;
          if (r_good + 1'b1 == LOCK_N) w_state_nxt = LOCKED;
        end else if (w_in_range) begin
          w_prev_nxt = w_bin;
          w_good_nxt = GW'(1);
        end else begin
          w_state_nxt = SEARCH;
        end
        LOCKED: if (w_match) begin
          w_prev_nxt = w_bin;
        end else begin
          w_err = 1'b1;
          if (w_in_range) begin
            w_prev_nxt  = w_bin;
            w_good_nxt  = GW'(1);
            w_state_nxt = SYNC;
          end else begin
            w_state_nxt = SEARCH;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SEARCH;
      r_prev   <= '0;
      r_good   <= '0;
      r_bin    <= '0;
      r_bvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_prev_nxt;
      r_good   <= w_good_nxt;
      r_bvalid <= bus.valid_in;
      r_err    <= w_err;
      if (bus.valid_in) r_bin <= w_bin;
    end
  end

`ifdef GRAY_ERR_CNT_EN
  logic [ERR_WIDTH-1:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (reset)                         r_err_cnt <= '0;
    else if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
  end
  assign bus.err_count = r_err_cnt;
`else
  assign bus.err_count = ERR_WIDTH'(0);
`endif

  assign bus.binario_out   = r_bin;
  assign bus.binario_valid = r_bvalid;
  assign bus.locked        = (r_state == LOCKED);
  assign bus.error         = r_err;
endmodule

// File: tb/tb_decodificador_gray.sv
// Directed bench: DUT a uses SIZE=32, DUT b uses SIZE=20.
module tb_decodificador_gray;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decodificador_gray_if #(.WIDTH(5), .ERR_WIDTH(8)) ifa ();
  decodificador_gray_if #(.WIDTH(5), .ERR_WIDTH(8)) ifb ();

  decodificador_gray #(.WIDTH(5), .SIZE(32), .LOCK_COUNT(4), .ERR_WIDTH(8))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  decodificador_gray #(.WIDTH(5), .SIZE(20), .LOCK_COUNT(4), .ERR_WIDTH(8))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct {
    logic [4:0] gray;
    logic [4:0] bin;
    logic       lock;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [4:0] enc(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int exp_cnt(input int n);
`ifdef GRAY_ERR_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit sel_b, input logic v, input logic [4:0] g);
    @(negedge clk);
    if (sel_b) begin ifb.valid_in = v; ifb.gray_in = g; end
    else       begin ifa.valid_in = v; ifa.gray_in = g; end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input int bin, input int lck, input int err, input int cnt);
    chk({name, ".bin"},   int'(ifa.binario_out),   bin);
    chk({name, ".bvld"},  int'(ifa.binario_valid), 1);
    chk({name, ".lock"},  int'(ifa.locked),        lck);
    chk({name, ".err"},   int'(ifa.error),         err);
    chk({name, ".cnt"},   int'(ifa.err_count),     cnt);
  endtask

  task automatic chk_b(input string name, input int bin, input int lck, input int err, input int cnt);
    chk({name, ".bin"},   int'(ifb.binario_out),   bin);
    chk({name, ".bvld"},  int'(ifb.binario_valid), 1);
    chk({name, ".lock"},  int'(ifb.locked),        lck);
    chk({name, ".err"},   int'(ifb.error),         err);
    chk({name, ".cnt"},   int'(ifb.err_count),     cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ifa.valid_in = 1'b0;
    ifb.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int v, errs;
    ifa.valid_in = 1'b0; ifa.gray_in = '0;
    ifb.valid_in = 1'b0; ifb.gray_in = '0;

    // Table: Gray 0,1,3,2 then the rest of the cycle and a wrap to 0,1
    vecs.push_back('{5'h00, 5'd0, 1'b0});
    vecs.push_back('{5'h01, 5'd1, 1'b0});
    vecs.push_back('{5'h03, 5'd2, 1'b0});
    vecs.push_back('{5'h02, 5'd3, 1'b1});
    for (int b = 4; b < 34; b++) vecs.push_back('{enc(b % 32), 5'(b % 32), 1'b1});

    repeat (2) @(posedge clk);
    #1;
    chk("rst.bin",  int'(ifa.binario_out),   0);
    chk("rst.bvld", int'(ifa.binario_valid), 0);
    chk("rst.lock", int'(ifa.locked),        0);
    chk("rst.err",  int'(ifa.error),         0);
    chk("rst.cnt",  int'(ifa.err_count),     0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].gray);
      chk_a($sformatf("vec%0d", i), vecs[i].bin, vecs[i].lock, 0, 0);
    end

    // Idle cycle: output holds, valid drops, lock kept
    step(1'b0, 1'b0, 5'h1F);
    chk("idle.bvld", int'(ifa.binario_valid), 0);
    chk("idle.bin",  int'(ifa.binario_out),   1);
    chk("idle.lock", int'(ifa.locked),        1);

    for (int b = 2; b <= 10; b++) step(1'b0, 1'b1, enc(b));
    chk_a("at10", 10, 1, 0, 0);
    step(1'b0, 1'b1, 5'h0F);
    chk_a("rep10", 10, 0, 1, exp_cnt(1));
    step(1'b0, 1'b1, enc(11));
    chk_a("re11", 11, 0, 0, exp_cnt(1));
    step(1'b0, 1'b1, enc(12));
    chk_a("re12", 12, 0, 0, exp_cnt(1));
    step(1'b0, 1'b1, enc(13));
    chk_a("re13", 13, 1, 0, exp_cnt(1));

    // Reset wins over a valid sample while locked
    @(negedge clk);
    reset = 1'b1; ifa.valid_in = 1'b1; ifa.gray_in = enc(14);
    @(posedge clk);
    #1;
    chk("rstv.lock", int'(ifa.locked),        0);
    chk("rstv.bvld", int'(ifa.binario_valid), 0);
    chk("rstv.cnt",  int'(ifa.err_count),     0);
    chk("rstv.bin",  int'(ifa.binario_out),   0);
    chk("rstv.err",  int'(ifa.error),         0);
    do_reset();

    // Saturation: lock, then repeat (error, relock) 300 times
    for (int b = 0; b < 4; b++) step(1'b0, 1'b1, enc(b));
    chk("sat.lock0", int'(ifa.locked), 1);
    v = 3; errs = 0;
    for (int k = 0; k < 300; k++) begin
      step(1'b0, 1'b1, enc(v));
      if (ifa.error === 1'b1) errs++;
      for (int j = 0; j < 3; j++) begin
        v = (v + 1) % 32;
        step(1'b0, 1'b1, enc(v));
        if (ifa.error === 1'b1) errs++;
      end
      if (k == 254) chk("sat.cnt255", int'(ifa.err_count), exp_cnt(255));
    end
    chk("sat.pulses", errs, 300);
    chk("sat.cnt",    int'(ifa.err_count), exp_cnt(300));
    chk("sat.lock",   int'(ifa.locked), 1);
    do_reset();

    // SIZE=20: legal wrap 19->0, then out-of-range 25 drops to SEARCH
    step(1'b1, 1'b1, enc(17)); chk_b("b17", 17, 0, 0, 0);
    step(1'b1, 1'b1, enc(18)); chk_b("b18", 18, 0, 0, 0);
    step(1'b1, 1'b1, enc(19)); chk_b("b19", 19, 0, 0, 0);
    step(1'b1, 1'b1, enc(0));  chk_b("b0",  0,  1, 0, 0);
    step(1'b1, 1'b1, enc(1));  chk_b("b1",  1,  1, 0, 0);
    step(1'b1, 1'b1, enc(25)); chk_b("b25", 25, 0, 1, exp_cnt(1));
    // From SEARCH four samples are needed to relock
    step(1'b1, 1'b1, enc(2));  chk_b("bs2", 2, 0, 0, exp_cnt(1));
    step(1'b1, 1'b1, enc(3));  chk_b("bs3", 3, 0, 0, exp_cnt(1));
    step(1'b1, 1'b1, enc(4));  chk_b("bs4", 4, 0, 0, exp_cnt(1));
    step(1'b1, 1'b1, enc(5));  chk_b("bs5", 5, 1, 0, exp_cnt(1));
    step(1'b1, 1'b0, enc(6));
    chk("b.idle", int'(ifb.binario_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decodificador_gray.md
# decodificador_gray

Receive-side companion to the team's 5-bit Gray-code counter. It samples a Gray-coded count stream, converts each sample to binary and checks that consecutive samples advance by exactly one modulo SIZE. A lock state machine reports when the stream is trustworthy, and mismatches are flagged and counted. It sits at the consumer end of any Gray-coded count link, typically after a clock-domain synchronizer.

## Interface

- WIDTH, 5, bit width of the Gray and binary values
- SIZE, 32, count modulus; legal values 0..SIZE-1; requires 2 ≤ SIZE ≤ 2^WIDTH
- LOCK_COUNT, 4, consecutive correct samples needed to declare lock; ≥ 2
- ERR_WIDTH, 8, width of the error counter

Ports, clock and reset first:

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- valid_in  in  1  gray_in is sampled on this cycle
- gray_in  in  WIDTH  Gray-coded count
- binario_out  out  WIDTH  registered binary value of the last accepted sample
- binario_valid  out  1  one-cycle pulse; binario_out was updated
- locked  out  1  high while the FSM is in LOCKED
- error  out  1  one-cycle pulse on a sequence violation while LOCKED
- err_count  out  ERR_WIDTH  saturating count of error pulses

## Operation

- Conversion: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. This is combinational, then registered.
- Expected value: exp = (prev == SIZE-1) ? 0 : prev+1. Comparison is done in binary, so a non-power-of-2 SIZE wrap is legal.
- Out-of-range sample (binary ≥ SIZE): always a mismatch, and never stored as prev.
- FSM states are SEARCH, SYNC and LOCKED. Reset enters SEARCH.
  - SEARCH, valid in-range: prev ← bin, good ← 1, go to SYNC.
  - SEARCH, valid out-of-range: stay in SEARCH.
  - SYNC, valid match: prev ← bin, good ← good+1. If good+1 == LOCK_COUNT, go to LOCKED.
  - SYNC, valid mismatch in-range: prev ← bin, good ← 1, stay in SYNC.
  - SYNC, valid out-of-range: go to SEARCH.
  - LOCKED, valid match: prev ← bin, stay in LOCKED.
  - LOCKED, valid mismatch: pulse error and increment err_count. For an in-range value, prev ← bin, good ← 1, go to SYNC. For an out-of-range value, go to SEARCH.
  - valid_in low: no state change in any state.
- No errors are raised outside LOCKED.
- Repeated sample (bin == prev) counts as a mismatch.
- err_count saturates at 2^ERR_WIDTH-1 and is cleared only by reset.
- binario_out and binario_valid update on every valid_in, including out-of-range values and in every state.

## Timing

- Reset values: binario_out = 0, binario_valid = 0, locked = 0, error = 0, err_count = 0, FSM = SEARCH, prev = 0, good = 0.
- Latency: for valid_in at edge N, binario_out, binario_valid, error, locked and err_count all reflect that sample after edge N.
- locked rises on the same edge as binario_valid for the LOCK_COUNT-th consecutive correct sample.
- locked falls on the same edge as the error pulse.
- Back-to-back valid_in every cycle is supported; throughput is one sample per clock.
- reset takes priority over valid_in on the same edge. The sample is discarded and all outputs go to their reset values.

## Configuration

- GRAY_ERR_CNT_EN defined: the err_count register and saturation logic are present as described.
- GRAY_ERR_CNT_EN undefined: err_count is constant 0 with no register. The error pulse and the FSM are unchanged.

## Test plan

- Reset, then Gray 0,1,3,2 (bin 0..3) on consecutive cycles -> binario_out 0,1,2,3; locked rises with the 4th sample; error stays 0.
- Lock, then feed a full cycle 0..31 plus wrap to 0 (SIZE=32) -> no error; locked stays 1 across the 31→0 wrap.
- Locked at bin 10, then inject Gray 0x0F (bin 10 repeated) -> one error pulse, err_count = 1, locked = 0. Then 11,12,13 -> locked re-asserts after bin 13.
- SIZE=20, WIDTH=5: sequence 17,18,19,0,1 -> locks, no error. Then inject bin 25 -> error, err_count increments, FSM goes to SEARCH.
- With GRAY_ERR_CNT_EN: force 300 errors with ERR_WIDTH=8 -> err_count holds at 255. Without the macro -> err_count = 0 throughout, error pulses unchanged.
- Assert reset together with valid_in while LOCKED -> next cycle locked = 0, binario_valid = 0, err_count = 0, binario_out = 0.
